// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner and heading decoder.
// Purely declarative; no latency and no flow control.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;

  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_DOWN  = 4'd9;
  localparam logic [3:0] KEY_LEFT  = 4'd4;

  // Lowest-index active-low row; only meaningful when some row is low.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    if (!r[2]) idx = 2'd2;
    if (!r[1]) idx = 2'd1;
    if (!r[0]) idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [3:0] col_mask(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key/heading event bundle; master is the scanner, slave the board/game side.
// Wires only; no latency and no flow control (events are single-cycle pulses).
interface keypad_scanner_if;
  logic [3:0] keypad_row;
  logic       game_over;
  logic [3:0] keypad_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] dir;
  logic       dir_valid;

  modport master (
    input  keypad_row, game_over,
    output keypad_col, key_code, key_valid, key_held, dir, dir_valid
  );

  modport slave (
    output keypad_row, game_over,
    input  keypad_col, key_code, key_valid, key_held, dir, dir_valid
  );
endinterface

// File: rtl/keypad_scanner_sync2.sv
// Parameterized-width two-flop synchronizer with a configurable reset value.
// Latency 2 cycles; no backpressure.
module sync2 #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and reversal-proof heading decode.
// key_valid DEBOUNCE_CNT cycles after debounce entry; no backpressure, events are single pulses.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] CNT_LAST   = BW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rs;
  state_t        state;
  logic [1:0]    col_idx;
  logic [1:0]    col_inc;
  logic [3:0]    col_drv;
  logic [DW-1:0] dwell;
  logic [BW-1:0] bcnt;
  logic [3:0]    pat;
  logic [1:0]    row_lat;
  logic [3:0]    acc_code;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_held;
  dir_t          dir;
  dir_t          dir_nxt;
  dir_t          heading;
  logic          dir_chg;
  logic          dir_valid;
  logic          is_dir_key;

  sync2 #(.W(4), .RST_VAL(4'b1111)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.keypad_row),
    .q   (rs)
  );

  assign col_inc  = col_idx + 2'd1;
  assign acc_code = {row_lat, col_idx};

  // Heading for the code about to be accepted; reversals and same-heading keys are dropped.
  always_comb begin
    dir_nxt    = dir;
    dir_chg    = 1'b0;
    heading    = dir;
    is_dir_key = 1'b1;
    case (acc_code)
      KEY_UP:    heading = UP;
      KEY_RIGHT: heading = RIGHT;
      KEY_DOWN:  heading = DOWN;
      KEY_LEFT:  heading = LEFT;
      default:   is_dir_key = 1'b0;
    endcase
    if (is_dir_key && !kp.game_over && heading != dir &&
        heading != dir_t'(dir ^ 2'b10)) begin
      dir_nxt = heading;
      dir_chg = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col_drv   <= 4'b1110;
      dwell     <= '0;
      bcnt      <= '0;
      pat       <= 4'hF;
      row_lat   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      dir       <= RIGHT;
      dir_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      dir_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (rs != 4'hF) begin
              pat     <= rs;
              row_lat <= low_row(rs);
              bcnt    <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_inc;
              col_drv <= col_mask(col_inc);
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (rs != pat) begin
            bcnt    <= '0;
            col_idx <= col_inc;
            col_drv <= col_mask(col_inc);
            state   <= SCAN;
          end else if (bcnt == CNT_LAST) begin
            bcnt      <= '0;
            key_code  <= acc_code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            dir       <= dir_nxt;
            dir_valid <= dir_chg;
            state     <= HELD;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        HELD: begin
          if (rs == 4'hF) begin
            bcnt  <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (rs != 4'hF) begin
            bcnt  <= '0;
            state <= HELD;
          end else if (bcnt == CNT_LAST) begin
            bcnt     <= '0;
            key_held <= 1'b0;
            col_idx  <= col_inc;
            col_drv  <= col_mask(col_inc);
            state    <= SCAN;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign kp.keypad_col = col_drv;
  assign kp.key_code   = key_code;
  assign kp.key_valid  = key_valid;
  assign kp.key_held   = key_held;
  assign kp.dir        = dir;
  assign kp.dir_valid  = dir_valid;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 switch matrix (SCAN_DIV=4, DEBOUNCE_CNT=8).
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = 16'h0;
  logic [3:0]  row_v;
  int          n_cmp = 0;
  int          n_err = 0;
  int          kv_cnt = 0;
  int          dv_cnt = 0;
  int          kv0, dv0, lat;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.keypad_col[c]) row_v[r] = 1'b0;
  end
  assign kp.keypad_row = row_v;

  always @(negedge clk) begin
    if (kp.key_valid) kv_cnt++;
    if (kp.dir_valid) dv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press key (r,c) on the first negedge of a fresh dwell of column c.
  task automatic press_key(input int r, input int c);
    int i;
    i = 0;
    while (kp.keypad_col[c] == 1'b0 && i < 200) begin @(negedge clk); i++; end
    while (kp.keypad_col[c] == 1'b1 && i < 200) begin @(negedge clk); i++; end
    if (i >= 200) chk("col_wait", 32'(i), 32'd0);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic wait_kv(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!kp.key_valid && n < 60);
  endtask

  task automatic wait_held_low(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (kp.key_held && n < 60);
  endtask

  task automatic press_release(input int r, input int c, input int hold);
    int n;
    press_key(r, c);
    wait_kv(n);
    repeat (hold) @(negedge clk);
    pressed[r*4+c] = 1'b0;
    wait_held_low(n);
  endtask

  initial begin
    kp.game_over = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(kp.keypad_col), 32'hE);
    chk("rst_dir", 32'(kp.dir), 32'd1);
    chk("rst_held", 32'(kp.key_held), 32'd0);
    chk("rst_kv", 32'(kp.key_valid), 32'd0);
    chk("rst_code", 32'(kp.key_code), 32'd0);
    chk("rst_dv", 32'(kp.dir_valid), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("step_col0", 32'(kp.keypad_col), 32'hE);
    @(negedge clk);
    chk("step_col1", 32'(kp.keypad_col), 32'hD);
    repeat (4) @(negedge clk);
    chk("step_col2", 32'(kp.keypad_col), 32'hB);

    // Clean press: row1/col2 = code 6 (right, same as current heading).
    kv0 = kv_cnt; dv0 = dv_cnt;
    press_key(1, 2);
    wait_kv(lat);
    chk("press_lat", 32'(lat), 32'd12);
    chk("press_code", 32'(kp.key_code), 32'd6);
    chk("press_held", 32'(kp.key_held), 32'd1);
    repeat (40) @(negedge clk);
    chk("hold_col_frozen", 32'(kp.keypad_col), 32'hB);
    pressed[6] = 1'b0;
    wait_held_low(lat);
    chk("release_lat", 32'(lat), 32'd11);
    chk("press_kv_once", 32'(kv_cnt - kv0), 32'd1);
    chk("press_dir", 32'(kp.dir), 32'd1);
    chk("press_no_dv", 32'(dv_cnt - dv0), 32'd0);

    // Reversal: left while heading right is ignored, then down is taken.
    kv0 = kv_cnt; dv0 = dv_cnt;
    press_release(1, 0, 5);
    chk("rev_code", 32'(kp.key_code), 32'd4);
    chk("rev_kv", 32'(kv_cnt - kv0), 32'd1);
    chk("rev_dir", 32'(kp.dir), 32'd1);
    chk("rev_no_dv", 32'(dv_cnt - dv0), 32'd0);
    press_release(2, 1, 5);
    chk("down_code", 32'(kp.key_code), 32'd9);
    chk("down_dir", 32'(kp.dir), 32'd2);
    chk("down_dv", 32'(dv_cnt - dv0), 32'd1);
    press_release(1, 2, 5);
    chk("right_dir", 32'(kp.dir), 32'd1);

    // Bounce on row0/col1, then a steady press of code 1 (up).
    kv0 = kv_cnt; dv0 = dv_cnt;
    for (int i = 0; i < 12; i++) begin
      pressed[1] = ~pressed[1];
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_no_kv", 32'(kv_cnt - kv0), 32'd0);
    chk("bounce_no_held", 32'(kp.key_held), 32'd0);
    press_release(0, 1, 5);
    chk("bounce_kv", 32'(kv_cnt - kv0), 32'd1);
    chk("bounce_code", 32'(kp.key_code), 32'd1);
    chk("bounce_dir", 32'(kp.dir), 32'd0);
    chk("bounce_dv", 32'(dv_cnt - dv0), 32'd1);

    press_release(1, 0, 5);
    chk("left_dir", 32'(kp.dir), 32'd3);

    // Freeze: game over, up would otherwise be legal from left.
    kp.game_over = 1'b1;
    kv0 = kv_cnt; dv0 = dv_cnt;
    press_release(0, 1, 5);
    chk("frz_kv", 32'(kv_cnt - kv0), 32'd1);
    chk("frz_code", 32'(kp.key_code), 32'd1);
    chk("frz_dir", 32'(kp.dir), 32'd3);
    chk("frz_no_dv", 32'(dv_cnt - dv0), 32'd0);
    kp.game_over = 1'b0;

    // Reset four cycles into debounce of code 9.
    kv0 = kv_cnt;
    press_key(2, 1);
    repeat (8) @(negedge clk);
    chk("pre_rst_col", 32'(kp.keypad_col), 32'hD);
    rst = 1'b1;
    #1;
    chk("mid_rst_col", 32'(kp.keypad_col), 32'hE);
    chk("mid_rst_dir", 32'(kp.dir), 32'd1);
    chk("mid_rst_code", 32'(kp.key_code), 32'd0);
    chk("mid_rst_held", 32'(kp.key_held), 32'd0);
    chk("mid_rst_kv", 32'(kp.key_valid), 32'd0);
    pressed[9] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_no_kv", 32'(kv_cnt - kv0), 32'd0);
    chk("post_rst_dir", 32'(kp.dir), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
